req_pending_latch: RTL and testbench
====================================

// Module: req_pending_latch
// PURPOSE
//  Upstream capture stage for the 4-input priority encoder. Detects rising edges
//  on level request lines and holds each as a sticky pending bit. Drives the
//  masked pending vector to the encoder. Presents one event at a time on a
//  valid/ready port, lowest index first, and clears the bit when it is accepted.
//  Counts per source the requests lost to an already-pending bit.
// PARAMETERS
//  N      4  number of request sources
//  IDX_W  2  index width, equals $clog2(N)
//  CNT_W  8  width of each saturating drop counter
// PORTS
//  clk          in   1      clock, all state updates on the rising edge
//  rst_n        in   1      synchronous reset, active-low
//  req_in       in   N      level request lines; a 0->1 transition is one event
//  mask_in      in   N      1 = source masked (stays pending, is never offered)
//  pending_out  out  N      pending & ~mask_in; feeds the priority encoder
//  evt_valid    out  1      an event is being offered
//  evt_idx      out  IDX_W  index of the offered source
//  evt_ready    in   1      consumer accepts the event when evt_valid=1
//  drop_sel     in   IDX_W  selects which drop counter appears on drop_cnt
//  drop_cnt     out  CNT_W  drop counter of the selected source (combinational mux)
//  drop_clr     in   1      pulse; clears all drop counters
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - Clears req_q, pending, every drop counter, evt_valid and evt_idx. FSM goes to IDLE.
//   - Reset applied mid-offer drops the event with no handshake.
//  Edge detect:
//   - rise[i] = req_in[i] & ~req_q[i].
//   - req_q <= req_in on every edge.
//   - A line held high gives exactly one event.
//   - req_in held high through reset gives one event on the first edge after reset.
//  Pending:
//   - rise[i] sets pending[i].
//   - rise[i] while pending[i]=1 and i is not being cleared that cycle:
//     drop_cnt[i] += 1, saturating at 2^CNT_W-1.
//  FSM, 2 states:
//   - IDLE: if (pending & ~mask_in) != 0, latch evt_idx = lowest set index,
//     set evt_valid=1, go to OFFER.
//   - OFFER: evt_valid and evt_idx stay stable until evt_valid & evt_ready.
//     On that cycle clear pending[evt_idx], evt_valid <= 0, go to IDLE.
//  Offers are never retracted:
//   - Masking the offered source during OFFER does not cancel the offer.
//   - A new lower-index request does not preempt the current offer.
//  Latency and throughput:
//   - req_in rising at edge t -> pending set at edge t -> evt_valid high after
//     edge t+1 (2 cycles).
//   - At most one event per 2 cycles, because of the mandatory IDLE cycle.
//  Simultaneous events:
//   - Accept-clear and a new rise on the same index in the same cycle:
//     set wins, pending stays 1, no drop counted.
//   - drop_clr and an increment in the same cycle: clear wins (counter = 0).
//  Masking and output:
//   - Masking never clears pending; unmasking lets the source be offered again.
//   - All-masked or no pending: FSM stays in IDLE, evt_valid=0.
//   - pending_out is combinational from the pending register and mask_in.
// TESTING
//  1. Reset, req_in=4'b0100 at cycle 1, evt_ready=1
//     -> evt_valid=1 with evt_idx=2 at cycle 3; pending_out=0 at cycle 4.
//  2. req_in=4'b1010 in one cycle, evt_ready=1
//     -> events idx=1 then idx=3, two cycles apart.
//  3. Hold evt_ready=0 and pulse req_in[0] 3 times
//     -> a single offer idx=0; drop_cnt[0]=2 with drop_sel=0.
//  4. mask_in=4'b0001, req_in[0] pulses -> no offer, pending_out=0.
//     Then unmask -> offer idx=0.
//  5. Pulse req_in[1] 300 times with evt_ready=0
//     -> drop_cnt[1]=255 (saturated). Then drop_clr -> drop_cnt[1]=0.
//  6. rst_n=0 during OFFER -> next cycle evt_valid=0, pending_out=0,
//     all counters 0.

Source files
------------

// File: rtl/req_pending_if.sv
// Handshake and status bundle between the request capture stage and its consumer.
// The master side drives the request and control lines; the slave is the capture block.
interface req_pending_if #(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
);
  logic [N-1:0]     req_in;
  logic [N-1:0]     mask_in;
  logic [N-1:0]     pending_out;
  logic             evt_valid;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_ready;
  logic [IDX_W-1:0] drop_sel;
  logic [CNT_W-1:0] drop_cnt;
  logic             drop_clr;

  modport master (
    output req_in, mask_in, evt_ready, drop_sel, drop_clr,
    input  pending_out, evt_valid, evt_idx, drop_cnt
  );

  modport slave (
    input  req_in, mask_in, evt_ready, drop_sel, drop_clr,
    output pending_out, evt_valid, evt_idx, drop_cnt
  );
endinterface

// File: rtl/req_pending_latch.sv
// Rising-edge request capture with sticky pending bits, a one-at-a-time event
// offer (lowest index first) and per-source saturating drop counters.
module req_pending_latch #(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  req_pending_if.slave bus
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state_q;
  logic [N-1:0]     req_q;
  logic [N-1:0]     pending_q;
  logic             evt_valid_q;
  logic [IDX_W-1:0] evt_idx_q;
  logic [CNT_W-1:0] drop_q [N];

  logic [N-1:0]     rise;
  logic [N-1:0]     avail;
  logic [N-1:0]     clr_vec;
  logic             accept;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  assign rise   = bus.req_in & ~req_q;
  assign avail  = pending_q & ~bus.mask_in;
  assign accept = (state_q == OFFER) & evt_valid_q & bus.evt_ready;

  always_comb begin
    clr_vec = '0;
    clr_vec[evt_idx_q] = accept;
  end

  // Edge detect and sticky pending; a fresh rise beats an accept-clear on the same bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= bus.req_in;
      pending_q <= rise | (pending_q & ~clr_vec);
    end
  end

  // Offer FSM: an offer, once made, holds until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|avail) begin
            evt_idx_q   <= lowest_idx(avail);
            evt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (accept) begin
            evt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Drop counters: a rise onto a bit that stays pending is lost; clear beats increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n || bus.drop_clr) begin
        drop_q[i] <= '0;
      end else if (rise[i] && pending_q[i] && !clr_vec[i]) begin
        drop_q[i] <= sat_inc(drop_q[i]);
      end
    end
  end

  assign bus.pending_out = avail;
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_idx     = evt_idx_q;
  assign bus.drop_cnt    = drop_q[bus.drop_sel];

endmodule

// File: tb/tb_req_pending_latch.sv
// Directed bench for req_pending_latch: edge capture, offer ordering, masking,
// drop counting with saturation and clear, and reset during an offer.
module tb_req_pending_latch;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  req_pending_if #(.N(4), .IDX_W(2), .CNT_W(8)) bus ();

  req_pending_latch #(.N(4), .IDX_W(2), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_offer(input string tag, input logic v, input logic [1:0] idx);
    chk({tag, "_valid"}, 32'(bus.evt_valid), 32'(v));
    if (v) chk({tag, "_idx"}, 32'(bus.evt_idx), 32'(idx));
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    bus.drop_sel = sel;
    #1;
    chk(tag, 32'(bus.drop_cnt), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.req_in    = '0;
    bus.mask_in   = '0;
    bus.evt_ready = 1'b0;
    bus.drop_sel  = '0;
    bus.drop_clr  = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.evt_valid), 0);
    chk("rst_idx", 32'(bus.evt_idx), 0);
    chk("rst_pend", 32'(bus.pending_out), 0);
    chk_cnt("rst_cnt0", 2'd0, 8'd0);
    rst_n = 1'b1;
    tick();

    // 1: single request, latency and held-high line
    bus.evt_ready = 1'b1;
    bus.req_in = 4'b0100;
    tick();
    chk("t1_pend_set", 32'(bus.pending_out), 32'h4);
    chk_offer("t1_no_offer_yet", 1'b0, 2'd0);
    tick();
    chk_offer("t1_offer", 1'b1, 2'd2);
    tick();
    chk_offer("t1_accepted", 1'b0, 2'd0);
    chk("t1_pend_clr", 32'(bus.pending_out), 0);
    tick();
    tick();
    chk_offer("t1_held_high_once", 1'b0, 2'd0);
    chk("t1_held_pend", 32'(bus.pending_out), 0);
    bus.req_in = 4'b0000;
    tick();

    // 2: two simultaneous requests served lowest first, two cycles apart
    bus.req_in = 4'b1010;
    tick();
    chk("t2_pend", 32'(bus.pending_out), 32'hA);
    bus.req_in = 4'b0000;
    tick();
    chk_offer("t2_first", 1'b1, 2'd1);
    tick();
    chk_offer("t2_gap", 1'b0, 2'd0);
    chk("t2_pend_left", 32'(bus.pending_out), 32'h8);
    tick();
    chk_offer("t2_second", 1'b1, 2'd3);
    tick();
    chk_offer("t2_done", 1'b0, 2'd0);
    chk("t2_pend_empty", 32'(bus.pending_out), 0);

    // 3: repeated pulses while stalled count as drops
    bus.evt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req_in = 4'b0001;
      tick();
      bus.req_in = 4'b0000;
      tick();
    end
    chk_offer("t3_single_offer", 1'b1, 2'd0);
    chk_cnt("t3_drop0", 2'd0, 8'd2);
    // accept and new rise on the same bit in one cycle: set wins, no drop
    bus.req_in = 4'b0001;
    bus.evt_ready = 1'b1;
    tick();
    chk_offer("t3_acc_rise_valid", 1'b0, 2'd0);
    chk("t3_acc_rise_pend", 32'(bus.pending_out), 32'h1);
    chk_cnt("t3_acc_rise_nodrop", 2'd0, 8'd2);
    bus.req_in = 4'b0000;
    tick();
    chk_offer("t3_reoffer", 1'b1, 2'd0);
    tick();
    chk("t3_pend_clr", 32'(bus.pending_out), 0);
    bus.evt_ready = 1'b0;

    // 4: masking holds pending without offering; unmask releases it
    bus.evt_ready = 1'b1;
    bus.mask_in = 4'b0001;
    bus.req_in = 4'b0001;
    tick();
    bus.req_in = 4'b0000;
    tick();
    chk_offer("t4_masked_no_offer", 1'b0, 2'd0);
    chk("t4_masked_pend", 32'(bus.pending_out), 0);
    tick();
    chk_offer("t4_masked_still_idle", 1'b0, 2'd0);
    bus.mask_in = 4'b0000;
    #1;
    chk("t4_unmask_pend", 32'(bus.pending_out), 32'h1);
    tick();
    chk_offer("t4_unmask_offer", 1'b1, 2'd0);
    tick();
    chk("t4_unmask_done", 32'(bus.pending_out), 0);
    // offers are neither preempted nor cancelled by masking
    bus.evt_ready = 1'b0;
    bus.req_in = 4'b1000;
    tick();
    bus.req_in = 4'b0000;
    tick();
    chk_offer("t4_offer3", 1'b1, 2'd3);
    bus.req_in = 4'b0001;
    tick();
    chk_offer("t4_no_preempt", 1'b1, 2'd3);
    chk("t4_pend_both", 32'(bus.pending_out), 32'h9);
    bus.req_in = 4'b0000;
    bus.mask_in = 4'b1000;
    tick();
    chk_offer("t4_mask_no_cancel", 1'b1, 2'd3);
    chk("t4_pend_masked3", 32'(bus.pending_out), 32'h1);
    bus.evt_ready = 1'b1;
    tick();
    chk_offer("t4_acc3", 1'b0, 2'd0);
    tick();
    chk_offer("t4_then0", 1'b1, 2'd0);
    tick();
    bus.mask_in = 4'b0000;
    #1;
    chk("t4_all_clear", 32'(bus.pending_out), 0);
    bus.evt_ready = 1'b0;

    // 5: saturation at 255, clear, and clear beating an increment
    for (int k = 0; k < 300; k++) begin
      bus.req_in = 4'b0010;
      tick();
      bus.req_in = 4'b0000;
      tick();
    end
    chk_offer("t5_offer1", 1'b1, 2'd1);
    chk_cnt("t5_sat", 2'd1, 8'd255);
    chk_cnt("t5_other_cnt", 2'd0, 8'd2);
    bus.drop_clr = 1'b1;
    tick();
    bus.drop_clr = 1'b0;
    chk_cnt("t5_clr", 2'd1, 8'd0);
    chk_cnt("t5_clr_all", 2'd0, 8'd0);
    bus.req_in = 4'b0010;
    bus.drop_clr = 1'b1;
    tick();
    bus.req_in = 4'b0000;
    bus.drop_clr = 1'b0;
    chk_cnt("t5_clr_wins", 2'd1, 8'd0);
    tick();
    bus.req_in = 4'b0010;
    tick();
    bus.req_in = 4'b0000;
    chk_cnt("t5_inc_after_clr", 2'd1, 8'd1);
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
    chk("t5_done", 32'(bus.pending_out), 0);

    // 6: reset during an offer, with a line held high through reset
    bus.req_in = 4'b0001;
    tick();
    bus.req_in = 4'b0000;
    tick();
    bus.req_in = 4'b0001;
    tick();
    bus.req_in = 4'b0000;
    tick();
    chk_offer("t6_pre_offer", 1'b1, 2'd0);
    chk_cnt("t6_pre_cnt0", 2'd0, 8'd1);
    rst_n = 1'b0;
    bus.req_in = 4'b0100;
    tick();
    chk_offer("t6_rst_valid", 1'b0, 2'd0);
    chk("t6_rst_idx", 32'(bus.evt_idx), 0);
    chk("t6_rst_pend", 32'(bus.pending_out), 0);
    for (int s = 0; s < 4; s++) chk_cnt($sformatf("t6_rst_cnt%0d", s), 2'(s), 8'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_held_rise", 32'(bus.pending_out), 32'h4);
    tick();
    chk_offer("t6_post_offer", 1'b1, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
